renkon_linebuf: RTL
===================

# renkon_linebuf

Window generator feeding the renkon convolution datapath. Accepts a row-major pixel stream of one square input map, one pixel per accepted cycle. Keeps the last FSIZE-1 rows in line buffers and emits every valid FSIZE×FSIZE window (stride 1, no padding) as the `pixel_in` array the conv core consumes. It is the producer end of the conv core's window interface.

## Interface
Parameters:
- DWIDTH, shared package value: pixel width, signed.
- FSIZE, shared package value: window edge; 3 or 5.
- MAXW, 32: maximum image width; line-buffer depth.
- LWIDTH, 10: width of the size/position counters.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- xrst  in  1  reset, asynchronous, active-low.
- buf_start  in  1  one-cycle pulse: latch img_size, clear position, enter ACTIVE.
- img_size  in  LWIDTH  map width = height; legal range FSIZE..MAXW; sampled only with buf_start.
- pixel_we  in  1  pixel_din valid this cycle.
- pixel_din  in  signed DWIDTH  input pixel.
- pixel_out  out  signed DWIDTH [FSIZE**2-1:0]  window; index r*FSIZE+c; r=0 top row, c=0 leftmost column.
- out_valid  out  1  pixel_out holds a complete valid window this cycle.
- buf_busy  out  1  high while ACTIVE.
- buf_done  out  1  one-cycle pulse, coincident with the final window's out_valid.

## Operation
- States: IDLE, ACTIVE. IDLE→ACTIVE on buf_start. ACTIVE→IDLE on acceptance of pixel (img_size-1, img_size-1). buf_start in ACTIVE restarts: counters cleared, size re-latched, state stays ACTIVE.
- Counters col, row (LWIDTH bits). Pixel accepted = pixel_we && ACTIVE && !buf_start. On accept: col++; at col==img_size-1, col←0 and row++.
- Line buffers lb[0..FSIZE-2], depth MAXW, addressed by col. Read is combinational. On accept: lb[0][col]←pixel_din and lb[k][col]←lb[k-1][col].
- Column vector, top to bottom: lb[FSIZE-2][col] … lb[0][col], pixel_din.
- On accept, window shifts left by one: win[r][c]←win[r][c+1], win[r][FSIZE-1]←column[r].
- out_valid (registered) ← accept && row≥FSIZE-1 && col≥FSIZE-1. Stale cross-row columns therefore never appear with out_valid high.
- buf_done (registered) ← accept of the last pixel.
- Per image: exactly (img_size-FSIZE+1)² windows, in row-major order of their top-left corner.
- pixel_we in IDLE: ignored, no state change.
- buf_start and pixel_we in the same cycle: start wins, pixel dropped.
- img_size outside FSIZE..MAXW: illegal, behaviour undefined; not tested.
- Pixel values pass through unmodified; there is no arithmetic.

## Timing
- Reset state: IDLE; col, row, out_valid, buf_busy, buf_done = 0; all window registers 0. Line-buffer contents are not reset.
- Latency: the window whose bottom-right pixel is accepted on edge k is on pixel_out with out_valid=1 during the cycle after edge k.
- out_valid and buf_done are high for exactly one cycle per qualifying accept.
- pixel_out holds its value between accepts.
- Back-to-back pixel_we gives one window per cycle; gaps in pixel_we stall everything with no loss.
- buf_busy falls on the edge that accepts the last pixel, the same edge that raises the final out_valid and buf_done.
- Asserting xrst mid-image aborts immediately to the reset state. Asserting buf_start mid-image clears out_valid on the next edge and discards partial rows.

## Structure
- Shared package holds DWIDTH, FSIZE and the state enum (IDLE/ACTIVE).
- Sub-module renkon_linebuf_row: one MAXW-deep register line with combinational read at col and write-on-accept. Instantiate FSIZE-1 of them in a generate loop, chained.
- Top level holds the FSM, counters, window registers and output flags.

## Test plan
Test stimulus uses FSIZE=3, with each pixel value = row*16+col.
- Reset: hold xrst low mid-stream, then release. Required: all outputs 0, IDLE, and subsequent pixel_we ignored until buf_start.
- buf_start with img_size=6, then 36 back-to-back pixels. Required: 16 windows. The first appears the cycle after pixel (2,2) is accepted, value {0,1,2,16,17,18,32,33,34}. The last is {51,52,53,67,68,69,83,84,85}, with buf_done high in that same cycle.
- Same image with random 0–3-cycle pixel_we gaps. Required: identical 16 windows in order, and out_valid only in cycles following accepts.
- img_size=3 with 9 pixels. Required: exactly one window {0,1,2,16,17,18,32,33,34}, with buf_done coincident, then IDLE.
- Restart: after 20 pixels of a 6×6 image, pulse buf_start with img_size=4, with pixel_we high in the same cycle. Required: that pixel dropped, old partial image discarded. The next 16 pixels yield 4 windows; the first is {0,1,2,16,17,18,32,33,34}.

Source files
------------

// File: rtl/renkon_linebuf_pkg.sv
// rtl/renkon_linebuf_pkg.sv - shared pixel width, window size and FSM state type
package renkon_linebuf_pkg;
  localparam int DWIDTH = 8;
  localparam int FSIZE  = 3;
  localparam int NWIN   = FSIZE * FSIZE;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/renkon_linebuf_if.sv
// rtl/renkon_linebuf_if.sv - pixel stream in, window stream out, control/status
interface renkon_linebuf_if
  import renkon_linebuf_pkg::*;
#(
  parameter int LWIDTH = 10
) ();
  logic                     buf_start;
  logic [LWIDTH-1:0]        img_size;
  logic                     pixel_we;
  logic signed [DWIDTH-1:0] pixel_din;
  logic signed [DWIDTH-1:0] pixel_out [NWIN];
  logic                     out_valid;
  logic                     buf_busy;
  logic                     buf_done;

  modport master (
    output buf_start, img_size, pixel_we, pixel_din,
    input  pixel_out, out_valid, buf_busy, buf_done
  );

  modport slave (
    input  buf_start, img_size, pixel_we, pixel_din,
    output pixel_out, out_valid, buf_busy, buf_done
  );
endinterface

// File: rtl/renkon_linebuf_row.sv
// rtl/renkon_linebuf_row.sv - one image line of storage, combinational read at addr
module renkon_linebuf_row
  import renkon_linebuf_pkg::*;
#(
  parameter int MAXW = 32,
  parameter int AW   = $clog2(MAXW)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic signed [DWIDTH-1:0] din,
  output logic signed [DWIDTH-1:0] dout
);
  logic signed [DWIDTH-1:0] mem [MAXW];

  // Contents are never reset: every column is rewritten before it can reach a valid window.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];
endmodule

// File: rtl/renkon_linebuf.sv
// rtl/renkon_linebuf.sv - sliding FSIZE x FSIZE window generator over a square pixel stream
module renkon_linebuf
  import renkon_linebuf_pkg::*;
#(
  parameter int MAXW   = 32,
  parameter int LWIDTH = 10
) (
  input logic              clk,
  input logic              xrst,
  renkon_linebuf_if.slave  bus
);
  localparam int AW = $clog2(MAXW);

  state_t                   state_q, state_d;
  logic [LWIDTH-1:0]        col, row, size;
  logic                     accept, col_last, last_pix;
  logic                     out_valid_q, buf_done_q;
  logic signed [DWIDTH-1:0] win    [FSIZE][FSIZE];
  logic signed [DWIDTH-1:0] lb_din [FSIZE-1];
  logic signed [DWIDTH-1:0] lb_dout[FSIZE-1];
  logic signed [DWIDTH-1:0] column [FSIZE];

  assign accept   = bus.pixel_we && (state_q == ACTIVE) && !bus.buf_start;
  assign col_last = (col == size - LWIDTH'(1));
  assign last_pix = col_last && (row == size - LWIDTH'(1));

  // Chain: lb[0] takes the incoming pixel, each deeper line takes the one above it.
  for (genvar k = 0; k < FSIZE - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_din[k] = bus.pixel_din;
    end else begin : g_tail
      assign lb_din[k] = lb_dout[k-1];
    end
    renkon_linebuf_row #(.MAXW(MAXW), .AW(AW)) u_row (
      .clk  (clk),
      .we   (accept),
      .addr (col[AW-1:0]),
      .din  (lb_din[k]),
      .dout (lb_dout[k])
    );
  end

  always_comb begin
    for (int r = 0; r < FSIZE - 1; r++) column[r] = lb_dout[FSIZE-2-r];
    column[FSIZE-1] = bus.pixel_din;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.buf_start)          state_d = ACTIVE;
    else if (accept && last_pix) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      col  <= '0;
      row  <= '0;
      size <= '0;
    end else if (bus.buf_start) begin
      col  <= '0;
      row  <= '0;
      size <= bus.img_size;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row + LWIDTH'(1);
      end else begin
        col <= col + LWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int r = 0; r < FSIZE; r++)
        for (int c = 0; c < FSIZE; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < FSIZE; r++) begin
        for (int c = 0; c < FSIZE - 1; c++) win[r][c] <= win[r][c+1];
        win[r][FSIZE-1] <= column[r];
      end
    end
  end

  // Both row and col gates keep windows that straddle a line wrap from ever being flagged.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      out_valid_q <= 1'b0;
      buf_done_q  <= 1'b0;
    end else begin
      out_valid_q <= accept && (row >= LWIDTH'(FSIZE-1)) && (col >= LWIDTH'(FSIZE-1));
      buf_done_q  <= accept && last_pix;
    end
  end

  for (genvar r = 0; r < FSIZE; r++) begin : g_out_r
    for (genvar c = 0; c < FSIZE; c++) begin : g_out_c
      assign bus.pixel_out[r*FSIZE+c] = win[r][c];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.buf_done  = buf_done_q;
  assign bus.buf_busy  = (state_q == ACTIVE);
endmodule
